// File: rtl/libv_pkg.sv
// Shared helpers for libv arbiters: one-hot decode and round-robin priority masking.
// Widths stay parameter-driven at the call site; MAX_CH bounds the channel count.
package libv_pkg;

  localparam int unsigned MAX_CH = 64;

  function automatic int oh2bin(input logic [MAX_CH-1:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) b = b | i;
    end
    return b;
  endfunction

  // Channel idx is in the high-priority window when it sits at or above the pointer.
  function automatic logic rr_mask_bit(input int idx, input int first);
    return idx >= first;
  endfunction

endpackage

// File: rtl/libv_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on upd.
// While hold is high the grant is pinned to the channel granted when hold rose.
module libv_rr_arb
  import libv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  input  logic         hold,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  held;
  logic [N-1:0]  masked;
  logic [N-1:0]  rr_gnt;
  int            win;

  // Lowest set bit of the masked request wins; fall back to the full request on wrap.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] & rr_mask_bit(i, int'(ptr));
    end
    if (|masked) rr_gnt = masked & (~masked + N'(1));
    else         rr_gnt = req & (~req + N'(1));
  end

  assign gnt = hold ? (held & req) : rr_gnt;

  always_comb begin
    win     = oh2bin(MAX_CH'(gnt));
    ptr_nxt = (win >= N - 1) ? '0 : PW'(win + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      held <= '0;
    end else begin
      if (!hold) held <= rr_gnt;
      if (upd)   ptr  <= ptr_nxt;
    end
  end

endmodule

// File: rtl/libv_arb_mux.sv
// Round-robin N:1 packet mux with one registered output stage; 1-cycle accept-to-output latency.
// Full throughput; out_rdy low with out_vld high freezes the output and drops every in_rdy.
module libv_arb_mux
  import libv_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_vld,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_rdy,
  output logic           out_vld,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [N-1:0]   out_sel,
  input  logic           out_rdy
);

  logic         ld;
  logic         acc;
  logic         lock;
  logic         upd;
  logic         sel_last;
  logic [N-1:0] gnt;
  logic [W-1:0] sel_data;

  assign ld = ~out_vld | out_rdy;

  // Pointer only advances on a packet's last beat, so fairness is per packet.
  libv_rr_arb #(.N(N)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (in_vld),
    .upd  (upd),
    .hold (lock),
    .gnt  (gnt)
  );

  assign in_rdy = gnt & {N{ld}};
  assign acc    = |(in_vld & in_rdy);
  assign upd    = acc & sel_last;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | ({W{gnt[i]}} & in_data[i*W +: W]);
      sel_last = sel_last | (gnt[i] & in_last[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel  <= '0;
      lock     <= 1'b0;
    end else if (acc) begin
      out_vld  <= 1'b1;
      out_data <= sel_data;
      out_last <= sel_last;
      out_sel  <= gnt;
      lock     <= ~sel_last;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
                                 out_vld && !out_rdy |=> $stable(out_data));
  for (genvar g = 0; g < N; g++) begin : g_in_proto
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
                                in_vld[g] && !in_rdy[g] |=> in_vld[g]);
  end
`endif

endmodule

// File: tb/tb_libv_arb_mux.sv
// Drives three libv_arb_mux instances (N=3/W=1, N=4/W=32, N=8/W=64) from shared stimulus
// and compares the selected one against a packet-level round-robin reference model.
module tb_libv_arb_mux;

  logic         clk;
  logic         rst;
  logic [7:0]   vld_all;
  logic [7:0]   last_all;
  logic [511:0] data_all;
  logic         out_rdy;
  int           active;
  int           n;
  int           w;
  int           checks;
  int           passed;

  logic [2:0]   vld3, rdy3, sel3, d3;
  logic         ov3, ol3;
  logic [0:0]   od3;
  logic [3:0]   vld4, rdy4, sel4;
  logic [127:0] d4;
  logic         ov4, ol4;
  logic [31:0]  od4;
  logic [7:0]   vld8, rdy8, sel8;
  logic         ov8, ol8;
  logic [63:0]  od8;

  logic [7:0]   ob_rdy, ob_sel;
  logic         ob_vld, ob_last;
  logic [63:0]  ob_data;

  assign vld3 = (active == 0) ? vld_all[2:0] : 3'b0;
  assign vld4 = (active == 1) ? vld_all[3:0] : 4'b0;
  assign vld8 = (active == 2) ? vld_all     : 8'b0;

  for (genvar i = 0; i < 3; i++) begin : g_d3
    assign d3[i] = data_all[i*64];
  end
  for (genvar i = 0; i < 4; i++) begin : g_d4
    assign d4[i*32 +: 32] = data_all[i*64 +: 32];
  end

  libv_arb_mux #(.N(3), .W(1)) dut3 (
    .clk(clk), .rst(rst), .in_vld(vld3), .in_data(d3), .in_last(last_all[2:0]),
    .in_rdy(rdy3), .out_vld(ov3), .out_data(od3), .out_last(ol3), .out_sel(sel3),
    .out_rdy(out_rdy));
  libv_arb_mux #(.N(4), .W(32)) dut4 (
    .clk(clk), .rst(rst), .in_vld(vld4), .in_data(d4), .in_last(last_all[3:0]),
    .in_rdy(rdy4), .out_vld(ov4), .out_data(od4), .out_last(ol4), .out_sel(sel4),
    .out_rdy(out_rdy));
  libv_arb_mux #(.N(8), .W(64)) dut8 (
    .clk(clk), .rst(rst), .in_vld(vld8), .in_data(data_all), .in_last(last_all),
    .in_rdy(rdy8), .out_vld(ov8), .out_data(od8), .out_last(ol8), .out_sel(sel8),
    .out_rdy(out_rdy));

  always_comb begin
    ob_rdy = '0; ob_sel = '0; ob_vld = 1'b0; ob_last = 1'b0; ob_data = '0;
    case (active)
      0: begin ob_rdy = {5'b0, rdy3}; ob_sel = {5'b0, sel3}; ob_vld = ov3; ob_last = ol3; ob_data = {63'b0, od3}; end
      1: begin ob_rdy = {4'b0, rdy4}; ob_sel = {4'b0, sel4}; ob_vld = ov4; ob_last = ol4; ob_data = {32'b0, od4}; end
      default: begin ob_rdy = rdy8; ob_sel = sel8; ob_vld = ov8; ob_last = ol8; ob_data = od8; end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- reference model (packet-level round robin) ----------------
  logic        m_vld, m_last, m_lock;
  logic [63:0] m_data;
  logic [7:0]  m_sel;
  int          m_owner, m_lw;
  logic [7:0]  obs_rdy, exp_rdy;

  function automatic logic [63:0] wmask();
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int model_winner();
    int c;
    if (m_lock) return vld_all[m_owner] ? m_owner : -1;
    for (int k = 0; k < n; k++) begin
      c = (m_lw + 1 + k) % n;
      if (vld_all[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_rdy();
    int win;
    win = model_winner();
    if ((!m_vld || out_rdy) && win >= 0) return 8'(1 << win);
    return 8'h00;
  endfunction

  task automatic model_tick();
    int win;
    if (rst) begin
      m_vld = 0; m_last = 0; m_data = '0; m_sel = '0; m_lock = 0; m_owner = 0; m_lw = n - 1;
      return;
    end
    win = model_winner();
    if ((!m_vld || out_rdy) && win >= 0) begin
      m_vld  = 1;
      m_data = data_all[win*64 +: 64] & wmask();
      m_last = last_all[win];
      m_sel  = 8'(1 << win);
      if (last_all[win]) begin m_lock = 0; m_lw = win; end
      else begin m_lock = 1; m_owner = win; end
    end else if (out_rdy) begin
      m_vld = 0;
    end
  endtask

  // Called at posedge+1 with inputs set; samples in_rdy mid-cycle, returns at next posedge+1.
  task automatic cycle();
    #3;
    obs_rdy = ob_rdy;
    exp_rdy = model_rdy();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] v);
    data_all[i*64 +: 64] = v;
  endtask

  task automatic set_dut(input int k);
    active = k;
    n = (k == 0) ? 3 : (k == 1) ? 4 : 8;
    w = (k == 0) ? 1 : (k == 1) ? 32 : 64;
  endtask

  task automatic do_reset();
    rst = 1; vld_all = '0; last_all = '0; out_rdy = 1;
    cycle();
    rst = 0;
  endtask

  // Retire accepted beats (finishing open packets) until every channel is idle.
  task automatic drain();
    int guard;
    guard = 0;
    out_rdy = 1;
    while (guard < 80) begin
      for (int i = 0; i < 8; i++) begin
        if (obs_rdy[i]) begin
          if (last_all[i]) vld_all[i] = 1'b0;
          else last_all[i] = 1'b1;
        end
      end
      if (m_lock && !vld_all[m_owner]) begin
        vld_all[m_owner] = 1'b1; last_all[m_owner] = 1'b1;
      end
      if (vld_all == 8'h00) break;
      cycle();
      guard++;
    end
    checks++;
    if (vld_all !== 8'h00) $display("FAIL drain_timeout: pending vld %h, required 00", vld_all);
    else passed++;
    obs_rdy = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; vld_all = '0; last_all = '0; out_rdy = 1;
    cycle();
    checks++; if (ob_vld  !== 1'b0)  $display("FAIL reset_vld n=%0d: got %b want 0", n, ob_vld);  else passed++;
    checks++; if (ob_data !== 64'h0) $display("FAIL reset_data n=%0d: got %h want 0", n, ob_data); else passed++;
    checks++; if (ob_last !== 1'b0)  $display("FAIL reset_last n=%0d: got %b want 0", n, ob_last); else passed++;
    checks++; if (ob_sel  !== 8'h00) $display("FAIL reset_sel n=%0d: got %h want 00", n, ob_sel); else passed++;
    checks++; if (obs_rdy !== 8'h00) $display("FAIL reset_rdy n=%0d: got %h want 00", n, obs_rdy); else passed++;
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    vld_all = 8'h04; set_lane(2, 64'hAA); last_all = 8'h04;
    cycle();
    checks++; if (obs_rdy !== 8'h04) $display("FAIL single_rdy: got %h want 04", obs_rdy); else passed++;
    checks++; if (ob_vld !== 1'b1)   $display("FAIL single_vld: got %b want 1", ob_vld); else passed++;
    checks++; if (ob_data !== 64'hAA) $display("FAIL single_data: got %h want aa", ob_data); else passed++;
    checks++; if (ob_sel !== 8'h04)  $display("FAIL single_sel: got %h want 04", ob_sel); else passed++;
    checks++; if (ob_last !== 1'b1)  $display("FAIL single_last: got %b want 1", ob_last); else passed++;
    vld_all = 8'h00;
    cycle();
    checks++; if (ob_vld !== 1'b0)    $display("FAIL single_idle_vld: got %b want 0", ob_vld); else passed++;
    checks++; if (ob_data !== 64'hAA) $display("FAIL single_idle_data: got %h want aa", ob_data); else passed++;
    drain();
  endtask

  task automatic test_round_robin();
    logic [63:0] want;
    do_reset();
    for (int i = 0; i < n; i++) begin
      set_lane(i, 64'h10 + 64'(i));
      vld_all[i] = 1'b1; last_all[i] = 1'b1;
    end
    for (int k = 0; k <= n; k++) begin
      cycle();
      want = (64'h10 + 64'(k % n)) & wmask();
      checks++; if (obs_rdy !== 8'(1 << (k % n))) $display("FAIL rr_rdy n=%0d k=%0d: got %h want %h", n, k, obs_rdy, 8'(1 << (k % n))); else passed++;
      checks++; if (ob_vld !== 1'b1) $display("FAIL rr_vld n=%0d k=%0d: got %b want 1", n, k, ob_vld); else passed++;
      checks++; if (ob_sel !== 8'(1 << (k % n))) $display("FAIL rr_sel n=%0d k=%0d: got %h want %h", n, k, ob_sel, 8'(1 << (k % n))); else passed++;
      checks++; if (ob_data !== want) $display("FAIL rr_data n=%0d k=%0d: got %h want %h", n, k, ob_data, want); else passed++;
    end
    drain();
  endtask

  task automatic test_lock(input int gap);
    do_reset();
    vld_all = 8'h01; set_lane(0, 64'h01); last_all = 8'h01;
    cycle();
    set_lane(0, 64'h02); set_lane(1, 64'h21); set_lane(2, 64'h31);
    vld_all = 8'h07; last_all = 8'h05;
    cycle();
    checks++; if (obs_rdy !== 8'h02)  $display("FAIL lock_first_rdy gap=%0d: got %h want 02", gap, obs_rdy); else passed++;
    checks++; if (ob_data !== 64'h21) $display("FAIL lock_beat1 gap=%0d: got %h want 21", gap, ob_data); else passed++;
    if (gap > 0) begin
      vld_all[1] = 1'b0;
      repeat (gap) begin
        cycle();
        checks++; if (obs_rdy !== 8'h00) $display("FAIL lock_gap_rdy: got %h want 00", obs_rdy); else passed++;
        checks++; if (ob_vld !== 1'b0)   $display("FAIL lock_gap_vld: got %b want 0", ob_vld); else passed++;
      end
    end
    set_lane(1, 64'h22); vld_all[1] = 1'b1;
    cycle();
    checks++; if (obs_rdy !== 8'h02)  $display("FAIL lock_mid_rdy gap=%0d: got %h want 02", gap, obs_rdy); else passed++;
    checks++; if (ob_data !== 64'h22) $display("FAIL lock_beat2 gap=%0d: got %h want 22", gap, ob_data); else passed++;
    set_lane(1, 64'h23); last_all[1] = 1'b1;
    cycle();
    checks++; if (ob_data !== 64'h23) $display("FAIL lock_beat3 gap=%0d: got %h want 23", gap, ob_data); else passed++;
    checks++; if (ob_last !== 1'b1)   $display("FAIL lock_last gap=%0d: got %b want 1", gap, ob_last); else passed++;
    vld_all[1] = 1'b0;
    cycle();
    checks++; if (ob_sel !== 8'h04)   $display("FAIL lock_next_sel gap=%0d: got %h want 04", gap, ob_sel); else passed++;
    checks++; if (ob_data !== 64'h31) $display("FAIL lock_next_data gap=%0d: got %h want 31", gap, ob_data); else passed++;
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    vld_all = 8'h01; set_lane(0, 64'h55); last_all = 8'h01;
    cycle();
    vld_all = 8'h02; set_lane(1, 64'h66); last_all = 8'h03; out_rdy = 0;
    repeat (5) begin
      cycle();
      checks++; if (ob_vld !== 1'b1)    $display("FAIL bp_vld: got %b want 1", ob_vld); else passed++;
      checks++; if (ob_data !== 64'h55) $display("FAIL bp_data: got %h want 55", ob_data); else passed++;
      checks++; if (obs_rdy !== 8'h00)  $display("FAIL bp_rdy: got %h want 00", obs_rdy); else passed++;
    end
    out_rdy = 1;
    cycle();
    checks++; if (obs_rdy !== 8'h02)  $display("FAIL bp_release_rdy: got %h want 02", obs_rdy); else passed++;
    checks++; if (ob_data !== 64'h66) $display("FAIL bp_release_data: got %h want 66", ob_data); else passed++;
    checks++; if (ob_sel !== 8'h02)   $display("FAIL bp_release_sel: got %h want 02", ob_sel); else passed++;
    vld_all = 8'h00;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    vld_all = 8'h08; set_lane(3, 64'h41); last_all = 8'h00;
    cycle();
    set_lane(3, 64'h42);
    cycle();
    checks++; if (ob_data !== 64'h42) $display("FAIL rstmid_beat2: got %h want 42", ob_data); else passed++;
    set_lane(3, 64'h43); rst = 1;
    cycle();
    checks++; if (ob_vld !== 1'b0)   $display("FAIL rstmid_vld: got %b want 0", ob_vld); else passed++;
    checks++; if (ob_sel !== 8'h00)  $display("FAIL rstmid_sel: got %h want 00", ob_sel); else passed++;
    rst = 0;
    set_lane(3, 64'h41); set_lane(0, 64'h0A); vld_all = 8'h09; last_all = 8'h01;
    cycle();
    checks++; if (obs_rdy !== 8'h01)  $display("FAIL rstmid_rdy: got %h want 01", obs_rdy); else passed++;
    checks++; if (ob_sel !== 8'h01)   $display("FAIL rstmid_sel_after: got %h want 01", ob_sel); else passed++;
    checks++; if (ob_data !== 64'h0A) $display("FAIL rstmid_data_after: got %h want 0a", ob_data); else passed++;
    drain();
  endtask

  task automatic test_random(input int cycles);
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < n; i++) begin
        if (obs_rdy[i] && $urandom_range(3) == 0) begin
          vld_all[i] = 1'b0;
        end else if (obs_rdy[i] || (!vld_all[i] && $urandom_range(2) == 0)) begin
          vld_all[i] = 1'b1;
          set_lane(i, {$urandom, $urandom});
          last_all[i] = ($urandom_range(2) != 0);
        end
      end
      out_rdy = ($urandom_range(3) != 0);
      cycle();
      checks++; if (obs_rdy !== exp_rdy) $display("FAIL rand_rdy n=%0d c=%0d: got %h want %h", n, c, obs_rdy, exp_rdy); else passed++;
      checks++; if (ob_vld !== m_vld)    $display("FAIL rand_vld n=%0d c=%0d: got %b want %b", n, c, ob_vld, m_vld); else passed++;
      checks++; if (ob_sel !== m_sel)    $display("FAIL rand_sel n=%0d c=%0d: got %h want %h", n, c, ob_sel, m_sel); else passed++;
      checks++; if (ob_last !== m_last)  $display("FAIL rand_last n=%0d c=%0d: got %b want %b", n, c, ob_last, m_last); else passed++;
      checks++; if (ob_data !== m_data)  $display("FAIL rand_data n=%0d c=%0d: got %h want %h", n, c, ob_data, m_data); else passed++;
    end
    drain();
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1; vld_all = '0; last_all = '0; data_all = '0; out_rdy = 1;
    obs_rdy = '0; exp_rdy = '0;
    set_dut(1);
    m_vld = 0; m_last = 0; m_data = '0; m_sel = '0; m_lock = 0; m_owner = 0; m_lw = n - 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      set_dut(k);
      test_reset();
      test_round_robin();
      if (k == 1) begin
        test_single();
        test_lock(0);
        test_lock(2);
        test_backpressure();
        test_reset_mid();
      end
      test_random(400);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
